// File: rtl/buf_capture_sched_if.sv
// ---------------------------------------------------------------------------
// buf_capture_sched_if
// Purpose : Groups the AXI4-Stream style buses of the capture scheduler.
//           The eight ADC lanes come in without back-pressure. The four
//           capture-buffer streams go out with per-buffer ready.
// Signals : adc_tdata  [8*DATA_WIDTH] eight ADC lanes, lane k at [k*DW +: DW]
//           adc_tvalid [8]            per-lane valid
//           buf_tdata  [4*DATA_WIDTH] four buffer streams, buffer b at [b*DW +: DW]
//           buf_tvalid [4]            per-buffer valid
//           buf_tready [4]            per-buffer ready
// Modports: master - scheduler side (drives buf_tdata/buf_tvalid)
//           slave  - ADC source / buffer sink side
// ---------------------------------------------------------------------------
interface buf_capture_sched_if #(
    parameter int DATA_WIDTH = 128
);
    logic [8*DATA_WIDTH-1:0] adc_tdata;
    logic [7:0]              adc_tvalid;
    logic [4*DATA_WIDTH-1:0] buf_tdata;
    logic [3:0]              buf_tvalid;
    logic [3:0]              buf_tready;

    modport master (
        input  adc_tdata, adc_tvalid, buf_tready,
        output buf_tdata, buf_tvalid
    );

    modport slave (
        output adc_tdata, adc_tvalid, buf_tready,
        input  buf_tdata, buf_tvalid
    );
endinterface

// File: rtl/buf_capture_sched.sv
// ---------------------------------------------------------------------------
// buf_capture_sched
// Purpose : Schedules fixed-length captures from eight ADC lanes into four
//           capture buffers. Each buffer is routed from a lane chosen at
//           request time. A beat is taken only on cycles where every
//           selected lane is valid. Beats that a buffer does not accept are
//           dropped and flagged in a sticky overflow bit.
// Ports   : aclk, aresetn     clock, asynchronous active-low reset
//           bus (master)      ADC lanes in, buffer streams out
//           chan_sel  [12]    lane select per buffer, buffer b at [3b+:3]
//           cap_len   [LEN]   beats per capture (0 rejects the request)
//           capture_i         single-cycle capture request
//           sysref_i          sysref level, used only with sync start
//           busy              capture in progress (acceptance .. DONE)
//           done              one-cycle pulse at capture completion
//           req_drop          one-cycle pulse for a rejected request
//           overflow  [4]     sticky per-buffer lost-beat flag
// Options : CAPTURE_SYNC_EN - when defined, an accepted capture waits in
//           SYNC for a sysref_i rising edge before entering RUN.
// ---------------------------------------------------------------------------
module buf_capture_sched #(
    parameter int DATA_WIDTH = 128,
    parameter int LEN_WIDTH  = 14
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    buf_capture_sched_if.master  bus,
    input  logic [11:0]          chan_sel,
    input  logic [LEN_WIDTH-1:0] cap_len,
    input  logic                 capture_i,
    input  logic                 sysref_i,
    output logic                 busy,
    output logic                 done,
    output logic                 req_drop,
    output logic [3:0]           overflow
);

`ifdef CAPTURE_SYNC_EN
    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_RUN, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

    state_t                             state_q, state_d;
    logic [11:0]                        sel_q;
    logic [LEN_WIDTH-1:0]               len_q;
    logic [LEN_WIDTH-1:0]               cnt_q;
    logic [3:0][DATA_WIDTH-1:0]         tdata_q;
    logic [3:0]                         tvalid_q;
    logic [3:0]                         ovf_q;
    logic                               drop_q;

    logic                               accept;
    logic                               all_vld;
    logic                               beat;
    logic [3:0][DATA_WIDTH-1:0]         lane_mux;

`ifdef CAPTURE_SYNC_EN
    logic sysref_q;
    logic sysref_rise;

    assign sysref_rise = sysref_i & ~sysref_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sysref_q <= 1'b0;
        end else begin
            sysref_q <= sysref_i;
        end
    end
`else
    logic unused_sysref;
    assign unused_sysref = sysref_i;
`endif

    assign accept = (state_q == S_IDLE) && capture_i && (cap_len != '0);

    // A beat needs every latched selected lane valid at once, so that all
    // buffers stay aligned to the same ADC sample.
    always_comb begin
        all_vld  = 1'b1;
        lane_mux = '0;
        for (int b = 0; b < 4; b++) begin
            all_vld     = all_vld & bus.adc_tvalid[sel_q[3*b +: 3]];
            lane_mux[b] = bus.adc_tdata[int'(sel_q[3*b +: 3])*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // The count is checked before qualifying, so the RUN cycle that
    // follows the final beat takes no extra beat.
    assign beat = (state_q == S_RUN) && all_vld && (cnt_q != len_q);

    // ---- state register ----
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef CAPTURE_SYNC_EN
                    state_d = S_SYNC;
`else
                    state_d = S_RUN;
`endif
                end
            end
`ifdef CAPTURE_SYNC_EN
            S_SYNC: if (sysref_rise) state_d = S_RUN;
`endif
            S_RUN:  if (cnt_q == len_q) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---- state-decoded outputs ----
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // ---- request latch, beat counter, buffer stage, flags ----
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sel_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= '0;
            ovf_q    <= '0;
            drop_q   <= 1'b0;
        end else begin
            drop_q   <= capture_i & ~accept;
            tvalid_q <= beat ? 4'hF : 4'h0;
            if (beat) begin
                tdata_q <= lane_mux;
            end
            if (accept) begin
                sel_q <= chan_sel;
                len_q <= cap_len;
                cnt_q <= '0;
                ovf_q <= '0;
            end else begin
                if (beat) begin
                    cnt_q <= cnt_q + LEN_WIDTH'(1);
                end
                // A refused beat is simply lost; it still counts toward the length.
                ovf_q <= ovf_q | (tvalid_q & ~bus.buf_tready);
            end
        end
    end

    assign bus.buf_tdata  = tdata_q;
    assign bus.buf_tvalid = tvalid_q;
    assign req_drop       = drop_q;
    assign overflow       = ovf_q;

endmodule

// File: doc/buf_capture_sched.md
BUF_CAPTURE_SCHED -- requirements
Module: buf_capture_sched

Interface
REQ-001 Parameter: DATA_WIDTH, 128, width of one ADC/buffer AXI4-Stream beat.
REQ-002 Parameter: LEN_WIDTH, 14, width of the capture-length field and beat counter.
REQ-003 Port: aclk  in  1  ADC AXI4-Stream clock; the only clock.
REQ-004 Port: aresetn  in  1  asynchronous active-low reset.
REQ-005 Port: adc_tdata  in  8*DATA_WIDTH  eight ADC lanes, lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-006 Port: adc_tvalid  in  8  per-lane valid; there is no ADC tready, so ADC data is never back-pressured.
REQ-007 Port: chan_sel  in  12  ADC lane select per buffer, 3 bits per buffer, buffer b at bits [3b+:3].
REQ-008 Port: cap_len  in  LEN_WIDTH  number of beats per capture.
REQ-009 Port: capture_i  in  1  single-cycle capture request, already synchronous to aclk.
REQ-010 Port: sysref_i  in  1  aclk-synchronous sysref level; used only when CAPTURE_SYNC_EN is defined.
REQ-011 Port: buf_tdata  out  4*DATA_WIDTH  data to the four capture buffers.
REQ-012 Port: buf_tvalid  out  4  per-buffer valid.
REQ-013 Port: buf_tready  in  4  per-buffer ready.
REQ-014 Port: busy  out  1  high from request acceptance until the end of the DONE state.
REQ-015 Port: done  out  1  one-cycle pulse when a capture completes.
REQ-016 Port: req_drop  out  1  one-cycle pulse when a request is rejected.
REQ-017 Port: overflow  out  4  sticky per-buffer flag: a beat was lost.

Function
REQ-018 The FSM SHALL use states IDLE, SYNC (present only with CAPTURE_SYNC_EN), RUN and DONE.
REQ-019 In IDLE, capture_i=1 with cap_len!=0 SHALL latch chan_sel and cap_len, clear overflow, clear the beat counter, set busy and go to RUN (or to SYNC when the macro is defined).
REQ-020 In IDLE, capture_i=1 with cap_len=0 SHALL pulse req_drop the next cycle and stay in IDLE.
REQ-021 capture_i asserted in any state other than IDLE SHALL be ignored and SHALL pulse req_drop one cycle later.
REQ-022 A beat SHALL be qualified in RUN on each cycle where every latched selected lane has adc_tvalid=1.
REQ-023 On a qualified beat, buf_tdata[b] SHALL register the selected lane's data, and buf_tvalid[b] SHALL be 1 for exactly the following cycle; otherwise buf_tvalid SHALL be 0.
REQ-024 Latency: with capture_i at cycle N and all lanes valid, the first buf_tvalid SHALL occur at cycle N+2.
REQ-025 The beat counter SHALL increment on each qualified beat; when the count reaches the latched cap_len, the FSM SHALL go to DONE.
REQ-026 DONE SHALL last one cycle, assert done, then return to IDLE with busy=0.
REQ-027 Two buffers MAY select the same lane, and both SHALL then receive identical data.
REQ-028 A cycle with buf_tvalid[b]=1 and buf_tready[b]=0 SHALL set overflow[b]; the beat is dropped and the capture length is unaffected.
REQ-029 Changes to chan_sel or cap_len during a capture SHALL have no effect until the next accepted request.

Reset
REQ-030 aresetn=0 SHALL immediately force IDLE, counter=0, and busy, done, req_drop, buf_tvalid and overflow to 0; buf_tdata SHALL be 0.
REQ-031 Reset asserted mid-capture SHALL abort the capture without a done pulse; operation SHALL resume on the first aclk edge after release.

Configuration
REQ-032 Macro CAPTURE_SYNC_EN defined: after acceptance the FSM SHALL wait in SYNC until a sysref_i rising edge, detected as sysref_i=1 with the previous-cycle value 0, and SHALL enter RUN on the cycle after that edge.
REQ-033 Macro CAPTURE_SYNC_EN undefined: the SYNC state and the sysref_i edge detector SHALL not exist, sysref_i SHALL be ignored, and REQ-024 latency applies.

Verification
REQ-034 chan_sel = {3'd7,3'd5,3'd2,3'd0}, cap_len=4, all lanes valid with counting data, capture_i at cycle 10 -> buf_tvalid=4'hF for cycles 12-15, buffers carry lanes 0/2/5/7, done at cycle 16, busy low at 17.
REQ-035 cap_len=0 with capture_i -> req_drop pulse, busy stays 0, and no buf_tvalid.
REQ-036 Second capture_i during RUN -> req_drop pulse, first capture completes with exactly cap_len beats.
REQ-037 adc_tvalid[2]=0 for 3 cycles mid-capture with lane 2 selected -> no beats on any buffer during those cycles, total beats still equal cap_len.
REQ-038 buf_tready[1]=0 for one beat -> overflow=4'b0010 and held sticky; cleared on the next accepted capture.
REQ-039 aresetn pulsed low during RUN -> all outputs 0 immediately and no done pulse; with CAPTURE_SYNC_EN and sysref rising 7 cycles after capture_i -> first buf_tvalid 2 cycles after the edge.
